// File: rtl/flash_line_arbiter_if.sv
// Fill-request and flash-reader bus for flash_line_arbiter.
// slave = arbiter side, master = requesters plus flash reader.
interface flash_line_arbiter_if #(
  parameter int LINE_SIZE = 128
);
  logic                 req0;
  logic                 req1;
  logic [23:0]          addr0;
  logic [23:0]          addr1;
  logic                 done0;
  logic                 done1;
  logic [LINE_SIZE-1:0] line;
  logic                 err;
  logic                 busy;
  logic                 fr_rd;
  logic [23:0]          fr_addr;
  logic                 fr_done;
  logic [LINE_SIZE-1:0] fr_line;

  modport master (
    output req0, req1, addr0, addr1,
    output fr_done, fr_line,
    input  done0, done1, line, err, busy,
    input  fr_rd, fr_addr
  );

  modport slave (
    input  req0, req1, addr0, addr1,
    input  fr_done, fr_line,
    output done0, done1, line, err, busy,
    output fr_rd, fr_addr
  );
endinterface

// File: rtl/flash_line_arbiter.sv
// Round-robin line-fill arbiter in front of the flash line reader,
// with same-line merging and a WAIT watchdog.
module flash_line_arbiter #(
  parameter int LINE_SIZE = 128,
  parameter int TIMEOUT   = 256
) (
  input  logic               clk,
  input  logic               rst,
  flash_line_arbiter_if.slave bus
);
  localparam int OFS = $clog2(LINE_SIZE / 8);
  localparam int TW  = $clog2(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t               r_state;
  logic                 r_lp;
  logic [1:0]           r_owner;
  logic [23:0]          r_fr_addr;
  logic [LINE_SIZE-1:0] r_line;
  logic                 r_err;
  logic [TW-1:0]        r_timer;

  logic                 w_any;
  logic                 w_both;
  logic                 w_win;
  logic                 w_match;
  logic [23-OFS:0]      w_tag0;
  logic [23-OFS:0]      w_tag1;
  logic [23-OFS:0]      w_tagw;
  logic [1:0]           w_own;

  assign w_tag0  = bus.addr0[23:OFS];
  assign w_tag1  = bus.addr1[23:OFS];
  assign w_any   = bus.req0 | bus.req1;
  assign w_both  = bus.req0 & bus.req1;
  // On a tie the port not granted last time wins
  assign w_win   = w_both ? ~r_lp : bus.req1;
  assign w_tagw  = w_win ? w_tag1 : w_tag0;
  assign w_match = w_tag0 == w_tag1;
  assign w_own   = (w_both && w_match) ? 2'b11
                 : (w_win ? 2'b10 : 2'b01);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_lp      <= 1'b1;
      r_owner   <= 2'b00;
      r_fr_addr <= '0;
      r_line    <= '0;
      r_err     <= 1'b0;
      r_timer   <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_fr_addr <= {w_tagw, {OFS{1'b0}}};
            r_owner   <= w_own;
            r_lp      <= w_win;
            r_state   <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_timer <= '0;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (bus.fr_done) begin
            r_line  <= bus.fr_line;
            r_err   <= 1'b0;
            r_state <= S_RESP;
          end else if (r_timer == TW'(TIMEOUT - 1)) begin
            r_err   <= 1'b1;
            r_state <= S_RESP;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        S_RESP: begin
          r_owner <= 2'b00;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.done0   = (r_state == S_RESP) & r_owner[0];
  assign bus.done1   = (r_state == S_RESP) & r_owner[1];
  assign bus.fr_rd   = r_state == S_ISSUE;
  assign bus.busy    = r_state != S_IDLE;
  assign bus.fr_addr = r_fr_addr;
  assign bus.line    = r_line;
  assign bus.err     = r_err;
endmodule

// File: tb/tb_flash_line_arbiter.sv
// Directed bench for flash_line_arbiter: one instance at the default
// timeout, one with TIMEOUT = 8 for the watchdog cases.
module tb_flash_line_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  flash_line_arbiter_if #(.LINE_SIZE(128)) ba ();
  flash_line_arbiter_if #(.LINE_SIZE(128)) bb ();

  flash_line_arbiter #(.LINE_SIZE(128), .TIMEOUT(256)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (ba)
  );

  flash_line_arbiter #(.LINE_SIZE(128), .TIMEOUT(8)) u_dut8 (
    .clk (clk),
    .rst (rst),
    .bus (bb)
  );

  localparam logic [127:0] D0 =
    128'hDEAD_0000_1111_2222_3333_4444_5555_BEEF;
  localparam logic [127:0] D1 =
    128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
  localparam logic [127:0] D2 =
    128'hAAAA_5555_AAAA_5555_AAAA_5555_AAAA_5555;

  task automatic check(string tag, logic [127:0] got,
                       logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called in the IDLE cycle holding the requests; returns in RESP.
  task automatic fill(string tag, logic [23:0] ea, logic e0,
                      logic e1, logic [127:0] data, int lat);
    int nrd;
    nrd = 0;
    tick();
    check({tag, ".rd"}, ba.fr_rd, 1);
    check({tag, ".addr"}, ba.fr_addr, ea);
    check({tag, ".busy"}, ba.busy, 1);
    for (int c = 2; c <= lat; c++) begin
      tick();
      nrd += int'(ba.fr_rd);
      if (c == lat) begin
        ba.fr_done = 1'b1;
        ba.fr_line = data;
      end
    end
    tick();
    ba.fr_done = 1'b0;
    check({tag, ".xrd"}, nrd, 0);
    check({tag, ".d0"}, ba.done0, e0);
    check({tag, ".d1"}, ba.done1, e1);
    check({tag, ".line"}, ba.line, data);
    check({tag, ".err"}, ba.err, 0);
  endtask

  initial begin
    ba.req0 = 0; ba.req1 = 0; ba.addr0 = 0; ba.addr1 = 0;
    ba.fr_done = 0; ba.fr_line = 0;
    bb.req0 = 0; bb.req1 = 0; bb.addr0 = 0; bb.addr1 = 0;
    bb.fr_done = 0; bb.fr_line = 0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
    check("rst.busy", ba.busy, 0);
    check("rst.rd", ba.fr_rd, 0);
    check("rst.done", {ba.done0, ba.done1}, 0);
    check("rst.line", ba.line, 0);
    check("rst.err", ba.err, 0);
    check("rst.addr", ba.fr_addr, 0);

    // single fill, fr_done in cycle 20
    ba.req0 = 1; ba.addr0 = 24'h00123A;
    fill("single", 24'h001230, 1, 0, D0, 20);
    ba.req0 = 0;
    tick();
    check("single.idle", ba.busy, 0);

    // tie after reset: port 0 first
    rst = 1'b1;
    tick();
    rst = 1'b0;
    ba.req0 = 1; ba.addr0 = 24'h000100;
    ba.req1 = 1; ba.addr1 = 24'h000200;
    fill("tie0", 24'h000100, 1, 0, D1, 3);
    ba.req0 = 0;
    tick();
    fill("tie1", 24'h000200, 0, 1, D2, 4);
    ba.req1 = 0;
    tick();

    // continuous contention: 0,1,0,1
    ba.req0 = 1; ba.req1 = 1;
    fill("rr0", 24'h000100, 1, 0, D0, 2);
    tick();
    fill("rr1", 24'h000200, 0, 1, D1, 5);
    tick();
    fill("rr2", 24'h000100, 1, 0, D2, 3);
    tick();
    fill("rr3", 24'h000200, 0, 1, D0, 2);
    ba.req0 = 0; ba.req1 = 0;
    tick();

    // merge of the same line
    ba.req0 = 1; ba.addr0 = 24'h004008;
    ba.req1 = 1; ba.addr1 = 24'h00400C;
    fill("merge", 24'h004000, 1, 1, D2, 6);
    ba.req0 = 0; ba.req1 = 0;
    tick();
    check("merge.idle", ba.busy, 0);

    // timeout on TIMEOUT=8 instance
    bb.req1 = 1; bb.addr1 = 24'h000505;
    tick();
    check("to.rd", bb.fr_rd, 1);
    check("to.addr", bb.fr_addr, 24'h000500);
    for (int c = 2; c <= 9; c++) tick();
    check("to.c9busy", bb.busy, 1);
    check("to.c9done", bb.done1, 0);
    tick();
    check("to.done1", bb.done1, 1);
    check("to.done0", bb.done0, 0);
    check("to.err", bb.err, 1);
    check("to.line", bb.line, 0);
    bb.req1 = 0;
    tick();
    check("to.c11busy", bb.busy, 0);
    tick();
    bb.fr_done = 1; bb.fr_line = D1;
    check("to.c12busy", bb.busy, 0);
    tick();
    bb.fr_done = 0;
    check("late.busy", bb.busy, 0);
    check("late.done", bb.done1, 0);
    check("late.line", bb.line, 0);

    // fr_done in the last WAIT cycle
    bb.req0 = 1; bb.addr0 = 24'h000600;
    for (int c = 1; c <= 9; c++) tick();
    check("edge.c9done", bb.done0, 0);
    bb.fr_done = 1; bb.fr_line = D2;
    tick();
    bb.fr_done = 0;
    check("edge.done0", bb.done0, 1);
    check("edge.err", bb.err, 0);
    check("edge.line", bb.line, D2);
    bb.req0 = 0;
    tick();

    // reset while in WAIT
    bb.req1 = 1; bb.addr1 = 24'h000700;
    for (int c = 1; c <= 5; c++) tick();
    check("rw.c5busy", bb.busy, 1);
    rst = 1'b1;
    bb.req1 = 0;
    tick();
    rst = 1'b0;
    check("rw.busy", bb.busy, 0);
    check("rw.done", bb.done1, 0);
    check("rw.line", bb.line, 0);
    bb.fr_done = 1; bb.fr_line = D0;
    tick();
    bb.fr_done = 0;
    check("rw.late", {bb.done0, bb.done1}, 0);
    check("rw.idle", bb.busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule
